// File: rtl/clock_set_controller.sv
// rtl/clock_set_controller.sv - alarm-clock timekeeping and set-mode step sequencer
//
// Turns the 1 Hz Tick into seconds/minutes/hours step pulses in RUN mode, and
// in the set modes steps the selected field from Inc_Btn with hold-to-repeat.
//
// Ports:
//   Clk        system clock
//   Clr        asynchronous active-low reset
//   Tick       one-cycle 1 Hz pulse from the timebase
//   Mode_Btn   synchronized mode button level
//   Inc_Btn    synchronized increment button level
//   Sec_Count  current seconds counter value (0-59)
//   Min_Count  current minutes counter value (0-59)
//   Hr_Count   current hours counter value (0-23)
//   Sec_Step   seconds counter Up/Enable pulse
//   Min_Step   minutes counter Up/Enable pulse
//   Hr_Step    hours counter Up/Enable pulse
//   Sec_Clr_n  one-cycle active-low clear to the seconds counter
//   Mode       00 RUN, 01 SET_HR, 10 SET_MIN
//   Blink      blank phase for the field being set
module clock_set_controller #(
    parameter int HOLD_TICKS = 2
) (
    input  logic       Clk,
    input  logic       Clr,
    input  logic       Tick,
    input  logic       Mode_Btn,
    input  logic       Inc_Btn,
    input  logic [5:0] Sec_Count,
    input  logic [5:0] Min_Count,
    input  logic [4:0] Hr_Count,
    output logic       Sec_Step,
    output logic       Min_Step,
    output logic       Hr_Step,
    output logic       Sec_Clr_n,
    output logic [1:0] Mode,
    output logic       Blink
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10,
        BAD     = 2'b11
    } state_t;

    localparam logic [3:0] HOLD_MAX = 4'(HOLD_TICKS);

    state_t     state;
    logic       mode_prev;
    logic       inc_prev;
    logic [3:0] hold_cnt;
    logic       mode_rise;
    logic       inc_rise;
    logic       set_step;
    logic       sec_at_max;
    logic       min_at_max;

    // Hours wrap is handled inside the hours counter, so its value never
    // influences sequencing.
    logic unused_hr;
    assign unused_hr = ^Hr_Count;

    assign mode_rise  = Mode_Btn & ~mode_prev;
    assign inc_rise   = Inc_Btn & ~inc_prev;
    assign sec_at_max = (Sec_Count == 6'd59);
    assign min_at_max = (Min_Count == 6'd59);
    assign Mode       = state;

    // One step per set-mode cycle: either a fresh press, or a Tick once the
    // hold counter has saturated. A press coinciding with a Tick is one step.
    always_comb begin
        set_step = 1'b0;
        if (Inc_Btn) begin
            if (inc_rise) begin
                set_step = 1'b1;
            end else if (Tick && (hold_cnt == HOLD_MAX)) begin
                set_step = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state     <= RUN;
            mode_prev <= 1'b0;
            inc_prev  <= 1'b0;
            hold_cnt  <= 4'd0;
            Sec_Step  <= 1'b0;
            Min_Step  <= 1'b0;
            Hr_Step   <= 1'b0;
            Sec_Clr_n <= 1'b1;
            Blink     <= 1'b0;
        end else begin
            mode_prev <= Mode_Btn;
            inc_prev  <= Inc_Btn;
            Sec_Step  <= 1'b0;
            Min_Step  <= 1'b0;
            Hr_Step   <= 1'b0;
            Sec_Clr_n <= 1'b1;

            case (state)
                RUN: begin
                    hold_cnt <= 4'd0;
                    Blink    <= 1'b0;
                    if (mode_rise) begin
                        // A Tick on this edge is dropped with the mode change.
                        state <= SET_HR;
                    end else if (Tick) begin
                        Sec_Step <= 1'b1;
                        Min_Step <= sec_at_max;
                        Hr_Step  <= sec_at_max & min_at_max;
                    end
                end

                SET_HR, SET_MIN: begin
                    if (mode_rise) begin
                        // Mode change wins; any Inc edge this cycle is lost.
                        hold_cnt <= 4'd0;
                        Blink    <= 1'b0;
                        if (state == SET_MIN) begin
                            state     <= RUN;
                            Sec_Clr_n <= 1'b0;
                        end else begin
                            state <= SET_MIN;
                        end
                    end else begin
                        if (Tick) begin
                            Blink <= ~Blink;
                        end
                        if (!Inc_Btn || inc_rise) begin
                            hold_cnt <= 4'd0;
                        end else if (Tick && (hold_cnt != HOLD_MAX)) begin
                            hold_cnt <= hold_cnt + 4'd1;
                        end
                        if (state == SET_HR) begin
                            Hr_Step <= set_step;
                        end else begin
                            Min_Step <= set_step;
                        end
                    end
                end

                default: begin
                    state    <= RUN;
                    hold_cnt <= 4'd0;
                    Blink    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_set_controller.sv
// tb/tb_clock_set_controller.sv - scoreboard bench for clock_set_controller
module tb_clock_set_controller;

    localparam int HOLD = 2;

    logic       Clk = 1'b0;
    logic       Clr = 1'b0;
    logic       Tick = 1'b0;
    logic       Mode_Btn = 1'b0;
    logic       Inc_Btn = 1'b0;
    logic [5:0] Sec_Count = 6'd0;
    logic [5:0] Min_Count = 6'd0;
    logic [4:0] Hr_Count = 5'd0;
    logic       Sec_Step;
    logic       Min_Step;
    logic       Hr_Step;
    logic       Sec_Clr_n;
    logic [1:0] Mode;
    logic       Blink;

    clock_set_controller #(.HOLD_TICKS(HOLD)) dut (
        .Clk       (Clk),
        .Clr       (Clr),
        .Tick      (Tick),
        .Mode_Btn  (Mode_Btn),
        .Inc_Btn   (Inc_Btn),
        .Sec_Count (Sec_Count),
        .Min_Count (Min_Count),
        .Hr_Count  (Hr_Count),
        .Sec_Step  (Sec_Step),
        .Min_Step  (Min_Step),
        .Hr_Step   (Hr_Step),
        .Sec_Clr_n (Sec_Clr_n),
        .Mode      (Mode),
        .Blink     (Blink)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       sec;
        logic       min;
        logic       hr;
        logic       clrn;
        logic [1:0] mode;
        logic       blink;
    } obs_t;

    localparam obs_t RESET_OBS = 7'b0001000;

    obs_t expq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   min_seen = 0;
    int   cycle = 0;
    bit   started = 1'b0;

    // Reference model: field being set, last button levels, ticks held, blink.
    int   m_mode = 0;
    bit   m_pm = 1'b0;
    bit   m_pi = 1'b0;
    bit   m_blink = 1'b0;
    int   m_hold = 0;

    function automatic obs_t actual_obs();
        obs_t a;
        a.sec   = Sec_Step;
        a.min   = Min_Step;
        a.hr    = Hr_Step;
        a.clrn  = Sec_Clr_n;
        a.mode  = Mode;
        a.blink = Blink;
        return a;
    endfunction

    task automatic compare(input string name, input obs_t act, input obs_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got sec=%b min=%b hr=%b clrn=%b mode=%b blink=%b, want sec=%b min=%b hr=%b clrn=%b mode=%b blink=%b",
                     name, cycle, act.sec, act.min, act.hr, act.clrn, act.mode, act.blink,
                     exp.sec, exp.min, exp.hr, exp.clrn, exp.mode, exp.blink);
        end
    endtask

    task automatic compare_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // What the outputs must show after the coming clock edge, given these inputs.
    function automatic obs_t model_step(input bit clr, input bit tick, input bit mb,
                                        input bit ib, input int s, input int m);
        obs_t e;
        bit   mode_press;
        bit   inc_press;
        bit   want;
        e = RESET_OBS;
        if (!clr) begin
            m_mode = 0; m_pm = 0; m_pi = 0; m_hold = 0; m_blink = 0;
            return e;
        end
        mode_press = mb && !m_pm;
        inc_press  = ib && !m_pi;
        m_pm = mb;
        m_pi = ib;
        if (mode_press) begin
            if (m_mode == 2) e.clrn = 1'b0;
            m_mode  = (m_mode + 1) % 3;
            m_blink = 0;
            m_hold  = 0;
        end else if (m_mode == 0) begin
            m_hold  = 0;
            m_blink = 0;
            if (tick) begin
                e.sec = 1'b1;
                e.min = (s == 59);
                e.hr  = (s == 59) && (m == 59);
            end
        end else begin
            want = 0;
            if (tick) m_blink = !m_blink;
            if (!ib) begin
                m_hold = 0;
            end else if (inc_press) begin
                m_hold = 0;
                want = 1;
            end else if (tick) begin
                if (m_hold >= HOLD) want = 1;
                else m_hold++;
            end
            if (want) begin
                if (m_mode == 1) e.hr = 1'b1;
                else e.min = 1'b1;
            end
        end
        e.mode  = 2'(m_mode);
        e.blink = m_blink;
        return e;
    endfunction

    task automatic drive(input bit clr, input bit tick, input bit mb, input bit ib,
                         input int s, input int m, input int h);
        @(negedge Clk);
        Clr       = clr;
        Tick      = tick;
        Mode_Btn  = mb;
        Inc_Btn   = ib;
        Sec_Count = 6'(s);
        Min_Count = 6'(m);
        Hr_Count  = 5'(h);
        expq.push_back(model_step(clr, tick, mb, ib, s, m));
        started = 1'b1;
        if (!clr) begin
            #1;
            compare("async_reset", actual_obs(), RESET_OBS);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, Mode_Btn, Inc_Btn, 0, 0, 0);
    endtask

    task automatic mode_pulse();
        drive(1, 0, 1, Inc_Btn, 0, 0, 0);
        drive(1, 0, 0, Inc_Btn, 0, 0, 0);
    endtask

    // Monitor: one expected observation per clock edge once stimulus runs.
    initial begin
        wait (started);
        forever begin
            @(posedge Clk);
            #1;
            cycle++;
            if (Min_Step) min_seen++;
            if (expq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL scoreboard_underflow cycle %0d: got empty queue, want entry", cycle);
            end else begin
                compare("outputs", actual_obs(), expq.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rmb;
        bit rib;

        // Reset then quiet running.
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        idle(10);

        // RUN carries.
        drive(1, 1, 0, 0, 59, 59, 23);
        idle(2);
        drive(1, 1, 0, 0, 30, 59, 23);
        idle(2);
        drive(1, 1, 0, 0, 59, 12, 5);
        idle(2);

        // SET_HR: single press, then Ticks toggle Blink without seconds.
        mode_pulse();
        drive(1, 0, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 59, 59, 0);
            idle(2);
        end

        // SET_MIN: hold Inc through five Ticks.
        mode_pulse();
        idle(2);
        min_seen = 0;
        drive(1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            idle(2);
            drive(1, 1, 0, 1, 0, 0, 0);
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        idle(3);
        compare_int("hold_repeat_min_steps", min_seen, 4);

        // SET_MIN -> RUN clears seconds; then press + Mode together in SET_HR.
        mode_pulse();
        idle(3);
        mode_pulse();
        idle(1);
        min_seen = 0;
        drive(1, 0, 1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        idle(3);
        compare_int("mode_inc_same_cycle_min_steps", min_seen, 0);
        mode_pulse();
        idle(2);

        // Reset during a hold in SET_HR.
        mode_pulse();
        drive(1, 0, 0, 1, 0, 0, 0);
        drive(1, 1, 0, 1, 0, 0, 0);
        drive(1, 1, 0, 1, 0, 0, 0);
        drive(0, 1, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Randomized operation.
        rmb = 0;
        rib = 0;
        for (int i = 0; i < 4000; i++) begin
            int s;
            int m;
            if ($urandom_range(0, 9) == 0) rmb = !rmb;
            if ($urandom_range(0, 5) == 0) rib = !rib;
            s = ($urandom_range(0, 2) == 0) ? 59 : int'($urandom_range(0, 59));
            m = ($urandom_range(0, 1) == 0) ? 59 : int'($urandom_range(0, 59));
            drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) == 0), rmb, rib,
                  s, m, int'($urandom_range(0, 23)));
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        idle(2);
        @(negedge Clk);
        compare_int("scoreboard_drained", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
